// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mresp_state_e;

  // Default widths, also used by the CPU bench
  localparam int unsigned MRESP_ADDR_W  = 8;
  localparam int unsigned MRESP_DATA_W  = 8;
  localparam int unsigned MRESP_DEPTH   = 256;
  localparam int unsigned MRESP_LATENCY = 2;

  // Wait counter is wide enough for LATENCY (max 15) plus a 2-bit random extension
  localparam int unsigned MRESP_CNT_W = 5;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mem_resp_lfsr.sv
// 8-bit Fibonacci LFSR with enable; supplies random extra wait states.
module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  logic feedback;

  // XOR of the tapped bits forms the new LSB
  always_comb begin
    feedback = ^(q & LFSR_TAPS);
  end

  // Shift left on each enabled edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[6:0], feedback};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: slave side of the CPU mem_req/mem_ready handshake,
// with a DEPTH-word array, programmable wait states and a backdoor port.
// Optional: define MEM_RAND_WAIT_EN to add 0..3 random wait states per request.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = MRESP_ADDR_W,
  parameter int unsigned DATA_W  = MRESP_DATA_W,
  parameter int unsigned DEPTH   = MRESP_DEPTH,
  parameter int unsigned LATENCY = MRESP_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [DATA_W-1:0] bd_wdata,
  output logic [DATA_W-1:0] bd_rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mresp_state_e            state_q, state_d;
  logic [MRESP_CNT_W-1:0]  cnt_q;
  logic [MRESP_CNT_W-1:0]  eff_lat;
  logic                    lat_we_q;
  logic [ADDR_W-1:0]       lat_addr_q;
  logic [DATA_W-1:0]       lat_wdata_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    accept;
  logic                    acc_fire;
  logic                    acc_we;
  logic [ADDR_W-1:0]       acc_addr;
  logic [DATA_W-1:0]       acc_wdata;
  logic                    acc_in_range;
  logic                    bd_in_range;

  assign accept = (state_q == IDLE) && mem_req;

`ifdef MEM_RAND_WAIT_EN
  logic [7:0] lfsr_dbg;

  mem_resp_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .q     (lfsr_dbg)
  );

  assign eff_lat = MRESP_CNT_W'(LATENCY) + MRESP_CNT_W'(lfsr_dbg[1:0]);
`else
  assign eff_lat = MRESP_CNT_W'(LATENCY);
`endif

  // Select the access source: zero latency uses the live request,
  // otherwise the request latched at acceptance
  always_comb begin
    acc_fire  = 1'b0;
    acc_we    = lat_we_q;
    acc_addr  = lat_addr_q;
    acc_wdata = lat_wdata_q;
    if (accept && (eff_lat == '0)) begin
      acc_fire  = 1'b1;
      acc_we    = mem_we;
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
    end else if ((state_q == WAIT) && (cnt_q == MRESP_CNT_W'(1))) begin
      acc_fire = 1'b1;
    end
    acc_in_range = (32'(acc_addr) < DEPTH);
    bd_in_range  = (32'(bd_addr) < DEPTH);
  end

  // FSM state register with async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_req) state_d = (eff_lat == '0) ? RESP : WAIT;
      WAIT:    if (cnt_q == MRESP_CNT_W'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded purely from the state register
  always_comb begin
    mem_ready = (state_q == RESP);
    mem_err   = (state_q == RESP) && err_q;
    busy      = (state_q != IDLE);
  end

  // Request latch, wait counter and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q       <= eff_lat;
        lat_we_q    <= mem_we;
        lat_addr_q  <= mem_addr;
        lat_wdata_q <= mem_wdata;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - MRESP_CNT_W'(1);
      end
      if (acc_fire) begin
        err_q   <= !acc_in_range;
        rdata_q <= (!acc_we && acc_in_range) ? mem_q[acc_addr[IDX_W-1:0]] : '0;
      end
    end
  end

  // Storage: frontdoor write is ordered last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (bd_we && bd_in_range) begin
      mem_q[bd_addr[IDX_W-1:0]] <= bd_wdata;
    end
    if (acc_fire && acc_we && acc_in_range) begin
      mem_q[acc_addr[IDX_W-1:0]] <= acc_wdata;
    end
  end

  // Backdoor combinational read, zero outside the array
  always_comb begin
    bd_rdata = bd_in_range ? mem_q[bd_addr[IDX_W-1:0]] : '0;
  end

  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with an expected-response queue.
module tb_mem_responder;

  localparam int unsigned LAT_A   = 2;
  localparam int unsigned DEPTH_A = 128;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic clk = 1'b0;
  logic rst_n;

  // DUT A: DEPTH=128, LATENCY=2
  logic       a_req, a_we, a_ready, a_err, a_busy, a_bd_we;
  logic [7:0] a_addr, a_wdata, a_rdata, a_bd_addr, a_bd_wdata, a_bd_rdata;
  // DUT Z: DEPTH=256, LATENCY=0
  logic       z_req, z_we, z_ready, z_err, z_busy, z_bd_we;
  logic [7:0] z_addr, z_wdata, z_rdata, z_bd_addr, z_bd_wdata, z_bd_rdata;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH_A), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready), .mem_err(a_err),
    .busy(a_busy), .bd_we(a_bd_we), .bd_addr(a_bd_addr), .bd_wdata(a_bd_wdata),
    .bd_rdata(a_bd_rdata)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .mem_req(z_req), .mem_we(z_we), .mem_addr(z_addr),
    .mem_wdata(z_wdata), .mem_rdata(z_rdata), .mem_ready(z_ready), .mem_err(z_err),
    .busy(z_busy), .bd_we(z_bd_we), .bd_addr(z_bd_addr), .bd_wdata(z_bd_wdata),
    .bd_rdata(z_bd_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write_a(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    a_bd_we = 1'b1; a_bd_addr = addr; a_bd_wdata = data;
    @(negedge clk);
    a_bd_we = 1'b0;
  endtask

  task automatic bd_write_z(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    z_bd_we = 1'b1; z_bd_addr = addr; z_bd_wdata = data;
    @(negedge clk);
    z_bd_we = 1'b0;
  endtask

  task automatic bd_peek_a(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    a_bd_addr = addr;
    #1;
    check(tag, a_bd_rdata, exp);
  endtask

  // One request on DUT A: checks latency, data, error flag and the one-cycle pulse
  task automatic xact_a(input string tag, input logic we, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err);
    int   n;
    logic seen;
    exp_t e;
    @(negedge clk);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_busy"}, a_busy, 1);
      check({tag, "_err_wo_ready"}, a_err & ~a_ready, 0);
      if (a_ready) seen = 1'b1;
    end
    a_req = 1'b0;
    check({tag, "_ready_seen"}, seen, 1);
    check({tag, "_latency"}, n, LAT_A + 1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, a_rdata, e.rdata);
      check({tag, "_err"}, a_err, e.err);
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, a_ready, 0);
    check({tag, "_rdata_hold"}, a_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses;
    exp_t e;

    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_bd_we = 0; a_bd_addr = '0; a_bd_wdata = '0;
    z_req = 0; z_we = 0; z_addr = '0; z_wdata = '0; z_bd_we = 0; z_bd_addr = '0; z_bd_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_a_ready", a_ready, 0);
    check("rst_a_err",   a_err,   0);
    check("rst_a_busy",  a_busy,  0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_z_ready", z_ready, 0);
    check("rst_z_busy",  z_busy,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read latency
    bd_write_a(8'h10, 8'h3C);
    bd_peek_a("bd_10", 8'h10, 8'h3C);
    xact_a("rd_10", 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0);

    // Write then read
    xact_a("wr_20", 1'b1, 8'h20, 8'h5A, 8'h00, 1'b0);
    bd_peek_a("bd_20", 8'h20, 8'h5A);
    xact_a("rd_20", 1'b0, 8'h20, 8'h00, 8'h5A, 1'b0);

    // Out of range (DEPTH=128): 0x90 would alias to 0x10 if truncated
    bd_peek_a("bd_90", 8'h90, 8'h00);
    xact_a("rd_90", 1'b0, 8'h90, 8'h00, 8'h00, 1'b1);
    xact_a("wr_90", 1'b1, 8'h90, 8'hE7, 8'h00, 1'b1);
    bd_peek_a("bd_10_after_wr90", 8'h10, 8'h3C);
    bd_write_a(8'h90, 8'hEE);
    bd_peek_a("bd_10_after_bd90", 8'h10, 8'h3C);

    // Back-to-back reads on the zero-latency instance
    bd_write_z(8'h01, 8'hC1);
    bd_write_z(8'h02, 8'hC2);
    bd_write_z(8'h03, 8'hC3);
    @(negedge clk);
    z_req = 1'b1; z_we = 1'b0; z_addr = 8'h01;
    sb.push_back('{rdata: 8'hC1, err: 1'b0});
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("b2b_ready_pattern", z_ready, c % 2);
      if (z_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("b2b_rdata", z_rdata, e.rdata);
          check("b2b_err", z_err, e.err);
        end
        pulses++;
        if (pulses < 3) begin
          z_addr = z_addr + 8'h01;
          sb.push_back('{rdata: 8'hC0 + z_addr, err: 1'b0});
        end else begin
          z_req = 1'b0;
        end
      end
    end
    check("b2b_pulses", pulses, 3);
    check("b2b_sb_empty", sb.size(), 0);

    // Reset during WAIT aborts the write
    bd_write_a(8'h30, 8'h11);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 8'h77;
    @(negedge clk);
    check("rstw_busy_wait", a_busy, 1);
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstw_busy_now", a_busy, 0);
    check("rstw_ready_now", a_ready, 0);
    repeat (2) begin
      @(negedge clk);
      check("rstw_ready_in_rst", a_ready, 0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rstw_ready_after", a_ready, 0);
    end
    check("rstw_rdata", a_rdata, 0);
    bd_peek_a("rstw_mem30", 8'h30, 8'h11);

    // Collision: frontdoor and backdoor write to 0x40 on the same edge
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wdata = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    check("coll_no_ready_early", a_ready, 0);
    a_bd_we = 1'b1; a_bd_addr = 8'h40; a_bd_wdata = 8'hBB;
    @(negedge clk);
    check("coll_ready", a_ready, 1);
    check("coll_err", a_err, 0);
    a_req = 1'b0;
    a_bd_we = 1'b0;
    bd_peek_a("coll_mem40", 8'h40, 8'hAA);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Data-memory responder: the slave end of the CPU's mem_req/mem_ready memory handshake.
- Holds a DEPTH-word storage array and answers each read or write request after a programmable number of wait states.
- Sits beside the CPU under the top-level bench and is driven directly by the CPU memory port.
- A backdoor port lets the bench preload and inspect memory without using the handshake.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data word width in bits.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_W.
- LATENCY, 2, number of wait cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  in  1  request from CPU; CPU holds we/addr/wdata stable while high.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  word address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data; valid while mem_ready=1.
- mem_ready  out  1  one-cycle response pulse.
- mem_err  out  1  one-cycle pulse coincident with mem_ready when the address is ≥ DEPTH.
- busy  out  1  high in WAIT and RESP states.
- bd_we  in  1  backdoor write strobe.
- bd_addr  in  ADDR_W  backdoor address.
- bd_wdata  in  DATA_W  backdoor write data.
- bd_rdata  out  DATA_W  combinational read of mem[bd_addr]; 0 if bd_addr ≥ DEPTH.

Behaviour:
- Clocking and reset: one clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - state=IDLE; mem_ready=0, mem_err=0, busy=0, mem_rdata=0; wait counter=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - At an edge with mem_req=1, latch we/addr/wdata and load cnt=LATENCY.
  - Next state is RESP if the effective latency is 0, else WAIT.
  - mem_req=0 → stay in IDLE.
- WAIT:
  - cnt decrements each edge.
  - At the edge where cnt==1, perform the access and go to RESP.
- Access (on the edge entering RESP):
  - Read: mem_rdata <= mem[addr].
  - Write: mem[addr] <= wdata; mem_rdata <= 0.
  - addr ≥ DEPTH: write dropped, mem_rdata <= 0, mem_err asserted in RESP.
- RESP:
  - mem_ready=1 (decoded from state, glitch-free) for exactly one cycle, then IDLE.
- Latency: request sampled at edge E0 → mem_ready is high in the cycle after edge E0+LATENCY.
  - LATENCY=0: ready in the cycle immediately after acceptance.
- mem_rdata holds its value after RESP until the next access.
- mem_req changes during WAIT/RESP are ignored; the latched request is used.
- Back-to-back: if mem_req is still high in the cycle after the RESP cycle, it is a new request, accepted from IDLE. Minimum spacing is one idle cycle.
- Backdoor write:
  - Commits at any clk edge regardless of state.
  - Same edge and same address as a frontdoor write commit: frontdoor wins.
  - bd_addr ≥ DEPTH: ignored.
- Reset mid-operation: the in-flight access is aborted with no write, and no mem_ready is issued.
- mem_err is never high without mem_ready.

Optional Feature:
- Macro: MEM_RAND_WAIT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'hA5) advances on each accepted request.
  - Effective latency = LATENCY + lfsr[1:0], sampled at acceptance.
  - The LFSR value is exposed as a debug-only internal signal for the bench.
- Undefined: latency is fixed at LATENCY and no LFSR logic is present.

Decomposition:
- Package mem_resp_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} mresp_state_e;
  - LFSR seed and tap constants;
  - default width constants shared with the CPU bench.
- Sub-module mem_resp_lfsr (8-bit LFSR with enable) is the natural split and is instantiated only under MEM_RAND_WAIT_EN.
- Storage array and FSM stay in mem_responder.

Test Plan:
- Read latency: backdoor mem[0x10]=0x3C, LATENCY=2; read 0x10 with req at E0 → mem_ready only in the cycle after E2, mem_rdata=0x3C, mem_err=0.
- Write then read: write 0x5A to 0x20; bd_rdata(0x20)=0x5A after mem_ready; CPU read of 0x20 returns 0x5A.
- Out of range: DEPTH=128, read 0x90 → mem_ready with mem_err=1, mem_rdata=0. Write 0x90 → no array change.
- Back-to-back: mem_req held high across 3 reads (0x01, 0x02, 0x03), LATENCY=0 → three ready pulses, each separated by exactly one idle cycle, data correct.
- Reset mid-WAIT: write 0x77 to 0x30 over old value 0x11; assert rst_n=0 during WAIT → no mem_ready, mem[0x30] stays 0x11, busy=0 immediately.
- Collision: frontdoor write 0xAA and backdoor write 0xBB both to 0x40 on the same commit edge → mem[0x40]=0xAA.
